// File: rtl/inst_fetch_ctrl.sv
// Instruction-fetch sequencer: owns the PC, reads the combinational ROM and
// buffers {pc, inst} in a small prefetch FIFO for decode, with redirect and halt/drain.
module inst_fetch_ctrl #(
  parameter int unsigned AW       = 6,
  parameter int unsigned DW       = 32,
  parameter int unsigned RESET_PC = 1,
  parameter int unsigned DEPTH    = 2
) (
  input  logic          clk,
  input  logic          rst,
  output logic [AW-1:0] rom_addr,
  input  logic [DW-1:0] rom_inst,
  output logic          id_valid,
  input  logic          id_ready,
  output logic [DW-1:0] id_inst,
  output logic [AW-1:0] id_pc,
  input  logic          redirect,
  input  logic [AW-1:0] redirect_pc,
  input  logic          halt,
  output logic          halted
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = PW + 1;
  localparam int unsigned EW = AW + DW;

  typedef enum logic [1:0] {FETCH, DRAIN, HALTED} state_t;

  state_t          state, nxt_state;
  logic [AW-1:0]   pc, nxt_pc;
  logic [EW-1:0]   mem [DEPTH];
  logic [PW-1:0]   rd_ptr, wr_ptr, nxt_rd_ptr, nxt_wr_ptr;
  logic [CW-1:0]   count, nxt_count;
  logic            pop_c, push_c;
  logic [EW-1:0]   nxt_head;

  assign rom_addr = pc;

  // Next-state, FIFO bookkeeping and the head word presented after this edge.
  always_comb begin
    nxt_state  = state;
    nxt_pc     = pc;
    nxt_rd_ptr = rd_ptr;
    nxt_wr_ptr = wr_ptr;
    nxt_count  = count;
    nxt_head   = '0;
    pop_c      = id_valid & id_ready;
    push_c     = (state == FETCH) & ~redirect & ((count < CW'(DEPTH)) | pop_c);

    if (redirect) begin
      nxt_pc     = redirect_pc;
      nxt_rd_ptr = '0;
      nxt_wr_ptr = '0;
      nxt_count  = '0;
    end else begin
      nxt_rd_ptr = rd_ptr + PW'(pop_c);
      nxt_wr_ptr = wr_ptr + PW'(push_c);
      nxt_count  = count + CW'(push_c) - CW'(pop_c);
      if (push_c) nxt_pc = pc + AW'(1);
    end

    unique case (state)
      FETCH:   if (halt) nxt_state = (nxt_count == '0) ? HALTED : DRAIN;
      DRAIN: begin
        if (!halt)                  nxt_state = FETCH;
        else if (nxt_count == '0)   nxt_state = HALTED;
      end
      HALTED:  if (!halt) nxt_state = FETCH;
      default: nxt_state = FETCH;
    endcase

    // The word being written this edge becomes the head when it lands in the slot read next.
    if (nxt_count != '0)
      nxt_head = (push_c && (nxt_rd_ptr == wr_ptr)) ? {pc, rom_inst} : mem[nxt_rd_ptr];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= FETCH;
      pc       <= AW'(RESET_PC);
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      id_valid <= 1'b0;
      id_pc    <= '0;
      id_inst  <= '0;
      halted   <= 1'b0;
    end else begin
      state            <= nxt_state;
      pc               <= nxt_pc;
      rd_ptr           <= nxt_rd_ptr;
      wr_ptr           <= nxt_wr_ptr;
      count            <= nxt_count;
      id_valid         <= (nxt_count != '0);
      {id_pc, id_inst} <= nxt_head;
      halted           <= (nxt_state == HALTED);
    end
  end

  // Storage needs no reset: count and pointers qualify every read.
  always_ff @(posedge clk) begin
    if (push_c) mem[wr_ptr] <= {pc, rom_inst};
  end

endmodule

// File: tb/tb_inst_fetch_ctrl.sv
// Bench for inst_fetch_ctrl: reference queue model checked every cycle,
// a vector table for the basic sequences and hand-written corner cases.
module tb_inst_fetch_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [5:0]  rom_addr;
  logic [31:0] rom_inst;
  logic        id_valid;
  logic        id_ready;
  logic [31:0] id_inst;
  logic [5:0]  id_pc;
  logic        redirect;
  logic [5:0]  redirect_pc;
  logic        halt;
  logic        halted;

  logic [31:0] rom [64];
  assign rom_inst = rom[rom_addr];

  always #5 clk = ~clk;

  inst_fetch_ctrl dut (
    .clk(clk), .rst(rst), .rom_addr(rom_addr), .rom_inst(rom_inst),
    .id_valid(id_valid), .id_ready(id_ready), .id_inst(id_inst), .id_pc(id_pc),
    .redirect(redirect), .redirect_pc(redirect_pc), .halt(halt), .halted(halted)
  );

  int n_chk  = 0;
  int n_fail = 0;

  // Reference model: expected FIFO contents, PC and state (0 fetch, 1 drain, 2 halted).
  logic [37:0] q[$];
  logic [5:0]  m_pc;
  int          m_st;

  typedef struct {
    logic        rst;
    logic        rdy;
    logic        rd;
    logic [5:0]  rpc;
    logic        h;
    logic        v;
    logic [5:0]  pc;
    logic [31:0] inst;
    logic [5:0]  addr;
  } vec_t;
  vec_t vecs[10];

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic check_model();
    logic [37:0] hd;
    hd = (q.size() != 0) ? q[0] : 38'h0;
    check("id_valid", 64'(id_valid), 64'(q.size() != 0));
    check("id_pc", 64'(id_pc), 64'(hd[37:32]));
    check("id_inst", 64'(id_inst), 64'(hd[31:0]));
    check("rom_addr", 64'(rom_addr), 64'(m_pc));
    check("halted", 64'(halted), 64'(m_st == 2));
  endtask

  // Called just after a rising edge: pulse reset between edges, check, release.
  task automatic do_reset();
    rst = 1'b1;
    #2;
    check("rst_valid", 64'(id_valid), 64'd0);
    check("rst_addr", 64'(rom_addr), 64'd1);
    rst = 1'b0;
    q.delete();
    m_pc = 6'd1;
    m_st = 0;
    #1;
    check_model();
  endtask

  task automatic step(input logic rdy, input logic rd, input logic [5:0] rpc, input logic h);
    int          cnt;
    bit          pop, push;
    logic [37:0] dummy;
    id_ready = rdy; redirect = rd; redirect_pc = rpc; halt = h;
    cnt  = q.size();
    pop  = (cnt != 0) && rdy;
    push = (m_st == 0) && !rd && ((cnt < 2) || pop);
    if (rd) begin
      q.delete();
      m_pc = rpc;
    end else begin
      if (pop) dummy = q.pop_front();
      if (push) begin
        q.push_back({m_pc, rom[m_pc]});
        m_pc = m_pc + 6'd1;
      end
    end
    cnt = q.size();
    case (m_st)
      0: if (h) m_st = (cnt == 0) ? 2 : 1;
      1: if (!h) m_st = 0; else if (cnt == 0) m_st = 2;
      default: if (!h) m_st = 0;
    endcase
    @(posedge clk);
    #1;
    check_model();
  endtask

  initial begin
    logic [5:0] popped[$];
    logic [5:0] frozen;
    logic       hreg;
    int         k;

    for (int a = 0; a < 64; a++) rom[a] = {8'hC0, 2'b00, 6'(a), 16'(a * 16'h1357)};
    rom[0]     = 32'h0;
    rom[1]     = 32'h00101464;
    rom[2]     = 32'h40000422;
    rom[3]     = 32'h38000866;
    rom[6'h0A] = 32'h04100841;
    rom[6'h0B] = 32'h04200823;

    vecs[0] = '{1'b1, 1'b0, 1'b0, 6'h00, 1'b0, 1'b0, 6'h00, 32'h00000000, 6'h01};
    vecs[1] = '{1'b0, 1'b1, 1'b0, 6'h00, 1'b0, 1'b1, 6'h01, 32'h00101464, 6'h02};
    vecs[2] = '{1'b0, 1'b1, 1'b0, 6'h00, 1'b0, 1'b1, 6'h02, 32'h40000422, 6'h03};
    vecs[3] = '{1'b0, 1'b1, 1'b0, 6'h00, 1'b0, 1'b1, 6'h03, 32'h38000866, 6'h04};
    vecs[4] = '{1'b1, 1'b0, 1'b0, 6'h00, 1'b0, 1'b0, 6'h00, 32'h00000000, 6'h01};
    vecs[5] = '{1'b0, 1'b0, 1'b0, 6'h00, 1'b0, 1'b1, 6'h01, 32'h00101464, 6'h02};
    vecs[6] = '{1'b0, 1'b0, 1'b0, 6'h00, 1'b0, 1'b1, 6'h01, 32'h00101464, 6'h03};
    vecs[7] = '{1'b0, 1'b0, 1'b1, 6'h0A, 1'b0, 1'b0, 6'h00, 32'h00000000, 6'h0A};
    vecs[8] = '{1'b0, 1'b1, 1'b0, 6'h00, 1'b0, 1'b1, 6'h0A, 32'h04100841, 6'h0B};
    vecs[9] = '{1'b0, 1'b1, 1'b0, 6'h00, 1'b0, 1'b1, 6'h0B, 32'h04200823, 6'h0C};

    rst = 1'b1; id_ready = 1'b0; redirect = 1'b0; redirect_pc = '0; halt = 1'b0;
    m_pc = 6'd1; m_st = 0;
    @(posedge clk);
    #1;

    // Basic sequence and redirect from a full FIFO.
    foreach (vecs[i]) begin
      if (vecs[i].rst) do_reset();
      else step(vecs[i].rdy, vecs[i].rd, vecs[i].rpc, vecs[i].h);
      check($sformatf("vec%0d_valid", i), 64'(id_valid), 64'(vecs[i].v));
      check($sformatf("vec%0d_pc", i), 64'(id_pc), 64'(vecs[i].pc));
      check($sformatf("vec%0d_inst", i), 64'(id_inst), 64'(vecs[i].inst));
      check($sformatf("vec%0d_addr", i), 64'(rom_addr), 64'(vecs[i].addr));
    end

    // Stall five cycles, then release: 01..04 with no loss or duplication.
    do_reset();
    for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 6'h00, 1'b0);
    check("stall_addr", 64'(rom_addr), 64'h03);
    check("stall_pc", 64'(id_pc), 64'h01);
    for (int i = 0; i < 4; i++) begin
      if (id_valid) popped.push_back(id_pc);
      step(1'b1, 1'b0, 6'h00, 1'b0);
    end
    check("release_cnt", 64'(popped.size()), 64'd4);
    for (int i = 0; i < popped.size(); i++)
      check($sformatf("release_pc%0d", i), 64'(popped[i]), 64'(i + 1));

    // Redirect to the last word: PC wraps to 00.
    step(1'b1, 1'b1, 6'h3F, 1'b0);
    step(1'b1, 1'b0, 6'h00, 1'b0);
    check("wrap_pc3f", 64'(id_pc), 64'h3F);
    step(1'b1, 1'b0, 6'h00, 1'b0);
    check("wrap_pc00", 64'(id_pc), 64'h00);
    check("wrap_addr", 64'(rom_addr), 64'h01);

    // Halt with a full FIFO: drain, freeze, resume at the frozen PC.
    do_reset();
    step(1'b0, 1'b0, 6'h00, 1'b0);
    step(1'b0, 1'b0, 6'h00, 1'b0);
    k = 0;
    while (halted !== 1'b1 && k < 10) begin
      step(1'b1, 1'b0, 6'h00, 1'b1);
      k++;
    end
    check("halt_reached", 64'(halted), 64'd1);
    frozen = rom_addr;
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 6'h00, 1'b1);
    check("halt_frozen", 64'(rom_addr), 64'(frozen));
    step(1'b1, 1'b0, 6'h00, 1'b0);
    step(1'b1, 1'b0, 6'h00, 1'b0);
    check("resume_pc", 64'(id_pc), 64'(frozen));

    // Reset pulse mid-stream, then restart.
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 6'h00, 1'b0);
    do_reset();
    step(1'b1, 1'b0, 6'h00, 1'b0);
    check("restart_pc", 64'(id_pc), 64'h01);
    check("restart_inst", 64'(id_inst), 64'h00101464);

    // Random mix of stalls, redirects and halts against the model.
    hreg = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 15) == 0) hreg = ~hreg;
      step(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 7) == 0),
           6'($urandom), hreg);
    end
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 6'h00, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
